bsg_cgol_ctrl: RTL and testbench
================================

// Module: bsg_cgol_ctrl
// PURPOSE
//   Controller directly upstream of the bsg_cgol_cell array. It accepts an initial board
//   and a generation count over a valid/ready handshake, loads the board into every cell,
//   and runs the requested number of generations. It then returns the final board over a
//   valid/yumi handshake. It drives the array's shared en/update controls and per-cell load values.
// PARAMETERS
//   board_width_p      16    board is board_width_p x board_width_p cells (>=3)
//   max_game_length_p  1000  largest accepted frames_i value
// PORTS
//   clk_i          in   1     clock, rising edge
//   reset_n_i      in   1     synchronous active-low reset
//   data_i         in   W*W   initial board, bit r*W+c = cell (r,c); W=board_width_p
//   frames_i       in   CW    generations to run; CW=$clog2(max_game_length_p+1)
//   v_i            in   1     input valid
//   ready_o        out  1     input ready
//   en_o           out  1     to all cells en_i: simulate one generation
//   update_o       out  1     to all cells update_i: load update_val_o
//   update_val_o   out  W*W   per-cell load value, bit i -> cell i update_val_i
//   cells_i        in   W*W   per-cell data_o from array
//   data_o         out  W*W   final board
//   v_o            out  1     output valid
//   yumi_i         in   1     output consumed (legal only when v_o=1)
// BEHAVIOUR
//   Clock and reset: one clock, clk_i. Reset is synchronous and active-low on reset_n_i.
//   Reset values: state=IDLE, ready_o=1, en_o=0, update_o=0, v_o=0.
//     board_r=0 and frame_cnt_r=0, so update_val_o=0.
//     data_o follows cells_i and is don't-care while v_o=0.
//   States: IDLE, LOAD, SIM, DONE. State and outputs are registered. data_o = cells_i (combinational).
//   IDLE:
//     ready_o=1. On v_i&ready_o: board_r<=data_i; frame_cnt_r<=frames_i; go to LOAD.
//   LOAD:
//     Lasts exactly 1 cycle. update_o=1; update_val_o=board_r.
//     Next state: SIM if frame_cnt_r!=0, else DONE.
//   SIM:
//     en_o=1 every cycle. frame_cnt_r decrements each cycle.
//     Go to DONE on the cycle frame_cnt_r==1, which is the last en_o cycle.
//     Exactly frames_i en_o cycles are issued.
//   DONE:
//     v_o=1. data_o = cells_i (cells are stable because en_o=0 and update_o=0).
//     On yumi_i go to IDLE. ready_o is low in DONE, so no bypass.
//   Latency: handshake at cycle t; update_o at t+1; en_o during t+2..t+1+N; v_o first high at t+2+N.
//     With N=0: v_o high at t+2.
//   Back-to-back: after yumi_i at cycle u, ready_o=1 at u+1. Throughput is 1 board per N+3 cycles.
//   Invariants:
//     en_o and update_o are never both 1.
//     ready_o and v_o are never both 1.
//     ready_o=0 outside IDLE; v_i is ignored then.
//   frames_i>max_game_length_p: truncated to CW bits. Caller must not send it.
//   Reset mid-operation: next cycle state is IDLE, en_o=0, update_o=0, v_o=0.
//     Cell contents are not reset; the next LOAD overwrites them.
//   yumi_i while v_o=0 is illegal; the block ignores it.
// TESTING
//   1. W=5, blinker (cells (2,1),(2,2),(2,3)), frames=1 -> v_o at t+3;
//      data_o = vertical (1,2),(2,2),(3,2).
//   2. Same blinker, frames=2 -> data_o equals the input. Exactly 2 en_o pulses, 1 update_o pulse.
//   3. 2x2 block still life, frames=0 -> no en_o pulse; v_o at t+2; data_o=input.
//   4. Glider, frames=4, yumi_i held 0 for 10 cycles -> v_o and data_o stable (glider shifted +1,+1);
//      ready_o=0 throughout; v_i pulses are ignored.
//   5. reset_n_i=0 for 1 cycle during SIM with frames=20 -> next cycle IDLE, en_o=0, ready_o=1;
//      new job with frames=1 gives a correct result.
//   6. Two jobs back-to-back, with yumi_i asserted the same cycle v_o rises -> second accept at u+1;
//      second result correct. A cell-level reference model checks every cycle.

Source files
------------

// File: rtl/bsg_cgol_ctrl.sv
// Game-of-life controller: accepts board+count, loads cells, runs N generations, returns board.
// Latency N+2 cycles from accept to v_o; input stalls (ready_o=0) until the result is taken with yumi_i.
module bsg_cgol_ctrl #(
    parameter int board_width_p     = 16,
    parameter int max_game_length_p = 1000,
    localparam int cells_lp         = board_width_p * board_width_p,
    localparam int cnt_width_lp     = $clog2(max_game_length_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [cells_lp-1:0]     data_i,
    input  logic [cnt_width_lp-1:0] frames_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic                    en_o,
    output logic                    update_o,
    output logic [cells_lp-1:0]     update_val_o,
    input  logic [cells_lp-1:0]     cells_i,
    output logic [cells_lp-1:0]     data_o,
    output logic                    v_o,
    input  logic                    yumi_i
);

    typedef enum logic [1:0] {IDLE, LOAD, SIM, DONE} state_e;

    state_e                  state_r, state_n;
    logic [cells_lp-1:0]     board_r;
    logic [cnt_width_lp-1:0] frame_cnt_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            board_r     <= '0;
            frame_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && v_i) begin
                board_r     <= data_i;
                frame_cnt_r <= frames_i;
            end else if (state_r == SIM) begin
                frame_cnt_r <= frame_cnt_r - cnt_width_lp'(1);
            end
        end
    end

    // Outputs decode straight from the state register, so they carry no combinational input paths.
    always_comb begin
        state_n  = state_r;
        ready_o  = 1'b0;
        en_o     = 1'b0;
        update_o = 1'b0;
        v_o      = 1'b0;
        case (state_r)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) state_n = LOAD;
            end
            LOAD: begin
                update_o = 1'b1;
                state_n  = (frame_cnt_r != '0) ? SIM : DONE;
            end
            SIM: begin
                en_o = 1'b1;
                if (frame_cnt_r == cnt_width_lp'(1)) state_n = DONE;
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign update_val_o = board_r;
    assign data_o       = cells_i;

endmodule

// File: tb/tb_bsg_cgol_ctrl.sv
// Directed bench for bsg_cgol_ctrl on a 5x5 board with a behavioural cell array behind it.
module tb_bsg_cgol_ctrl;

    localparam int W  = 5;
    localparam int N  = W * W;
    localparam int CW = $clog2(1000 + 1);

    localparam logic [N-1:0] BLINK_H = 25'h0003800;
    localparam logic [N-1:0] BLINK_V = 25'h0021080;
    localparam logic [N-1:0] BLOCK   = 25'h00018C0;
    localparam logic [N-1:0] GLIDER  = 25'h0001C82;
    localparam logic [N-1:0] GLIDER4 = 25'h0072080;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  data_in = '0;
    logic [CW-1:0] frames = '0;
    logic          v_in = 1'b0;
    logic          ready;
    logic          en;
    logic          update;
    logic [N-1:0]  update_val;
    logic [N-1:0]  cells;
    logic [N-1:0]  data_out;
    logic          v_out;
    logic          yumi = 1'b0;

    int checks = 0;
    int errors = 0;

    bsg_cgol_ctrl #(.board_width_p(W), .max_game_length_p(1000)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .data_i(data_in), .frames_i(frames),
        .v_i(v_in), .ready_o(ready), .en_o(en), .update_o(update),
        .update_val_o(update_val), .cells_i(cells), .data_o(data_out),
        .v_o(v_out), .yumi_i(yumi)
    );

    always #5 clk = ~clk;

    // Life rule on a bounded board: everything outside the edge counts as dead.
    function automatic logic [N-1:0] next_gen(input logic [N-1:0] b);
        logic [N-1:0] n;
        n = '0;
        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < W &&
                            (c + dc) >= 0 && (c + dc) < W)
                            cnt += int'(b[(r + dr) * W + (c + dc)]);
                    end
                end
                n[r * W + c] = (cnt == 3) || (b[r * W + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (update)  cells <= update_val;
        else if (en) cells <= next_gen(cells);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("en_update_excl", 32'(en & update), 32'd0);
        check("ready_v_excl", 32'(ready & v_out), 32'd0);
    endtask

    task automatic start_job(input logic [N-1:0] d, input int n, input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        data_in = d;
        frames  = CW'(n);
        v_in    = 1'b1;
        tick();
        v_in = 1'b0;
        check({tag, "_update"}, 32'(update), 32'd1);
        check({tag, "_update_val"}, 32'(update_val), 32'(d));
        check({tag, "_ready_low"}, 32'(ready), 32'd0);
    endtask

    task automatic wait_done(input int n, input logic [N-1:0] exp, input string tag);
        int cyc = 0, ens = 0, ups = 0;
        do begin
            tick();
            cyc++;
            if (!v_out) begin
                ens += int'(en);
                ups += int'(update);
            end
        end while (!v_out && cyc < 100);
        check({tag, "_v_o"}, 32'(v_out), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        check({tag, "_en_pulses"}, 32'(ens), 32'(n));
        check({tag, "_extra_update"}, 32'(ups), 32'd0);
        check({tag, "_data_o"}, 32'(data_out), 32'(exp));
    endtask

    task automatic consume(input string tag);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        check({tag, "_v_low"}, 32'(v_out), 32'd0);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_en", 32'(en), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        check("rst_v", 32'(v_out), 32'd0);
        check("rst_update_val", 32'(update_val), 32'd0);
        reset_n = 1'b1;

        // Stray yumi in IDLE must be ignored.
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        check("idle_yumi_ready", 32'(ready), 32'd1);
        check("idle_yumi_update", 32'(update), 32'd0);

        start_job(BLINK_H, 1, "blink1");
        wait_done(1, BLINK_V, "blink1");
        consume("blink1");

        start_job(BLINK_H, 2, "blink2");
        wait_done(2, BLINK_H, "blink2");
        consume("blink2");

        start_job(BLOCK, 0, "block0");
        wait_done(0, BLOCK, "block0");
        consume("block0");

        start_job(GLIDER, 4, "glider");
        wait_done(4, GLIDER4, "glider");
        for (int i = 0; i < 10; i++) begin
            v_in    = 1'b1;
            data_in = BLOCK;
            frames  = CW'(3);
            tick();
            check("stall_v", 32'(v_out), 32'd1);
            check("stall_data", 32'(data_out), 32'(GLIDER4));
            check("stall_ready", 32'(ready), 32'd0);
            check("stall_update", 32'(update), 32'd0);
        end
        v_in = 1'b0;
        consume("glider");

        start_job(GLIDER, 20, "midrst");
        tick();
        tick();
        tick();
        check("midrst_in_sim", 32'(en), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_en", 32'(en), 32'd0);
        check("midrst_update", 32'(update), 32'd0);
        check("midrst_v", 32'(v_out), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        start_job(BLINK_H, 1, "postrst");
        wait_done(1, BLINK_V, "postrst");
        consume("postrst");

        // Back-to-back: yumi on the first v_o cycle, next job already presented.
        start_job(BLINK_V, 1, "b2b_a");
        wait_done(1, BLINK_H, "b2b_a");
        yumi    = 1'b1;
        v_in    = 1'b1;
        data_in = GLIDER;
        frames  = CW'(4);
        tick();
        yumi = 1'b0;
        check("b2b_ready_u1", 32'(ready), 32'd1);
        check("b2b_v_low", 32'(v_out), 32'd0);
        start_job(GLIDER, 4, "b2b_b");
        wait_done(4, GLIDER4, "b2b_b");
        consume("b2b_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
